// File: rtl/fft_twiddle_gen.sv
// Radix-2 DIF twiddle stream: one (re, im) Q1.6 coefficient per butterfly, stage by stage.
// Latency 1 cycle from start; holds the beat while tw_ready=0. Optional macro TWGEN_CONJ_EN adds inv (IFFT conjugates).
module fft_twiddle_gen #(
   parameter int LOG2N = 4,
   parameter int TW_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
`ifdef TWGEN_CONJ_EN
   input  logic                       inv,
`endif
   input  logic                       tw_ready,
   output logic                       tw_valid,
   output logic [TW_W-1:0]            tw_re,
   output logic [TW_W-1:0]            tw_im,
   output logic [$clog2(LOG2N)-1:0]   stage,
   output logic [LOG2N-2:0]           bfly,
   output logic                       tw_last,
   output logic                       busy,
   output logic                       done
);

   localparam int N    = 1 << LOG2N;
   localparam int HALF = N / 2;
   localparam int QN   = N / 4;
   localparam int SW   = $clog2(LOG2N);
   localparam int BW   = LOG2N - 1;
   localparam longint TWO_PI_Q28 = 64'sd1686629713;

   // round(64*cos(2*pi*i/N)) via a Q28 Taylor series, evaluated at elaboration
   function automatic int cos_q6(input int i);
      longint x, x2, term, sum;
      x    = (TWO_PI_Q28 * longint'(i)) >>> LOG2N;
      x2   = (x * x) >>> 28;
      term = longint'(1) <<< 28;
      sum  = term;
      for (int n = 1; n <= 12; n++) begin
         term = -((term * x2) >>> 28) / longint'((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      return int'((sum * 64 + (longint'(1) <<< 27)) >>> 28);
   endfunction

   logic signed [TW_W-1:0] rom [0:QN];

   for (genvar g = 0; g <= QN; g++) begin : g_rom
      localparam int CV = cos_q6(g);
      assign rom[g] = TW_W'(CV);
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;

   logic                   conj;
   logic                   accept, wrap, final_beat, nxt_last;
   logic [SW-1:0]          nxt_s;
   logic [BW-1:0]          nxt_k, k_mask, e, re_idx, im_idx;
   logic                   re_neg;
   logic signed [TW_W-1:0] lut_re, lut_im;

`ifdef TWGEN_CONJ_EN
   logic inv_q;
   // inv is live only on the start cycle; afterwards the captured copy rules
   assign conj = (state == IDLE) ? inv : inv_q;
`else
   assign conj = 1'b0;
`endif

   assign accept     = tw_valid & tw_ready;
   assign wrap       = (bfly == BW'(HALF - 1));
   assign final_beat = wrap && (stage == SW'(LOG2N - 1));

   always_comb begin
      nxt_s = '0;
      nxt_k = '0;
      if (state == RUN) begin
         nxt_k = bfly + 1'b1;
         nxt_s = wrap ? stage + 1'b1 : stage;
      end
   end

   assign nxt_last = (nxt_s == SW'(LOG2N - 1)) && (nxt_k == BW'(HALF - 1));

   // e = (k mod (N >> (s+1))) << s, looked up from the next-state counters
   always_comb begin
      k_mask = BW'(HALF - 1) >> nxt_s;
      e      = (nxt_k & k_mask) << nxt_s;
      re_idx = e;
      im_idx = BW'(QN) - e;
      re_neg = 1'b0;
      if (e > BW'(QN)) begin
         re_idx = '0 - e;
         im_idx = e - BW'(QN);
         re_neg = 1'b1;
      end
      lut_re = re_neg ? -rom[re_idx] : rom[re_idx];
      lut_im = conj ? rom[im_idx] : -rom[im_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tw_valid <= 1'b0;
         tw_re    <= '0;
         tw_im    <= '0;
         stage    <= '0;
         bfly     <= '0;
         tw_last  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef TWGEN_CONJ_EN
         inv_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  tw_valid <= 1'b1;
                  stage    <= nxt_s;
                  bfly     <= nxt_k;
                  tw_re    <= lut_re;
                  tw_im    <= lut_im;
                  tw_last  <= nxt_last;
`ifdef TWGEN_CONJ_EN
                  inv_q    <= inv;
`endif
               end
            end
            RUN: begin
               if (accept) begin
                  if (final_beat) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     tw_valid <= 1'b0;
                     stage    <= '0;
                     bfly     <= '0;
                     tw_re    <= '0;
                     tw_im    <= '0;
                     tw_last  <= 1'b0;
                  end else begin
                     stage    <= nxt_s;
                     bfly     <= nxt_k;
                     tw_re    <= lut_re;
                     tw_im    <= lut_im;
                     tw_last  <= nxt_last;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed bench for fft_twiddle_gen at N=16: full schedules, stall, ignored restart, mid-run reset.
module tb_fft_twiddle_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       tw_ready = 1'b1;
`ifdef TWGEN_CONJ_EN
   logic       inv = 1'b0;
`endif
   logic       tw_valid;
   logic [7:0] tw_re, tw_im;
   logic [1:0] stage;
   logic [2:0] bfly;
   logic       tw_last, busy, done;

   int checks = 0;
   int failures = 0;

   // forward twiddle for exponent e = 0..7 at N=16, hand-rounded from 64*cos / -64*sin
   int exp_re [8] = '{64, 59, 45, 24, 0, -24, -45, -59};
   int exp_im [8] = '{0, -24, -45, -59, -64, -59, -45, -24};

   fft_twiddle_gen #(.LOG2N(4), .TW_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
`ifdef TWGEN_CONJ_EN
      .inv      (inv),
`endif
      .tw_ready (tw_ready),
      .tw_valid (tw_valid),
      .tw_re    (tw_re),
      .tw_im    (tw_im),
      .stage    (stage),
      .bfly     (bfly),
      .tw_last  (tw_last),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " valid"}, int'(tw_valid), 0);
      chk({tag, " re"}, int'($signed(tw_re)), 0);
      chk({tag, " im"}, int'($signed(tw_im)), 0);
      chk({tag, " stage"}, int'(stage), 0);
      chk({tag, " bfly"}, int'(bfly), 0);
      chk({tag, " last"}, int'(tw_last), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
   endtask

   // stall: hold ready low 3 cycles at stage 2 bfly 5; restart_at/abort_at: beat index or -1
   task automatic run_sched(input bit stall, input int restart_at, input int abort_at, input bit conj);
      int beat = 0;
      int cyc = 0;
      int held = 0;
      int s, k, e, sgn;
      sgn = conj ? -1 : 1;
      tw_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
`ifdef TWGEN_CONJ_EN
      inv = conj;
`endif
      @(negedge clk);
      start = 1'b0;
      while (beat < 32 && cyc < 400) begin
         if (beat == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_idle("async_rst");
            @(negedge clk);
            chk_idle("in_rst");
            rst_n = 1'b1;
            return;
         end
         s = beat / 8;
         k = beat % 8;
         e = (k % (8 >> s)) * (1 << s);
         chk($sformatf("valid b%0d", beat), int'(tw_valid), 1);
         chk($sformatf("busy b%0d", beat), int'(busy), 1);
         chk($sformatf("stage b%0d", beat), int'(stage), s);
         chk($sformatf("bfly b%0d", beat), int'(bfly), k);
         chk($sformatf("re b%0d", beat), int'($signed(tw_re)), exp_re[e]);
         chk($sformatf("im b%0d", beat), int'($signed(tw_im)), sgn * exp_im[e]);
         chk($sformatf("last b%0d", beat), int'(tw_last), (beat == 31) ? 1 : 0);
         chk($sformatf("done b%0d", beat), int'(done), 0);
         start = (beat == restart_at);
`ifdef TWGEN_CONJ_EN
         if (conj) inv = ~inv;
`endif
         if (stall && s == 2 && k == 5 && held < 3) begin
            tw_ready = 1'b0;
            held++;
         end else begin
            tw_ready = 1'b1;
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      tw_ready = 1'b1;
`ifdef TWGEN_CONJ_EN
      inv = 1'b0;
`endif
      if (cyc >= 400) chk("sched_timeout", cyc, 0);
      chk("done_pulse", int'(done), 1);
      chk("done valid", int'(tw_valid), 0);
      chk("done busy", int'(busy), 0);
      if (stall) chk("stall_cycles", held, 3);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_idle("in_reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_idle("idle");
      run_sched(1'b0, -1, -1, 1'b0);
      repeat (3) @(negedge clk);
      chk_idle("post_done");
      run_sched(1'b1, -1, -1, 1'b0);
      run_sched(1'b0, 3, 10, 1'b0);
      repeat (2) @(negedge clk);
      chk_idle("post_reset");
      run_sched(1'b0, -1, -1, 1'b0);
`ifdef TWGEN_CONJ_EN
      run_sched(1'b0, -1, -1, 1'b1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
